// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM encoding and address field helpers.
// Used by the refill controller and the decode stage.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } refill_state_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Core, memory and cache-array signals of the refill controller.
// CACHE_REFILL_STATS_EN adds the miss/drop counter outputs.
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  logic                iAccessValid;
  logic                iHit;
  logic [ADDR_W-1:0]   iAddress;
  logic                iFlush;
  logic                oStall;
  logic                oMemReqValid;
  logic [ADDR_W-1:0]   oMemReqAddr;
  logic                iMemReqReady;
  logic                iMemRespValid;
  logic [DATA_W-1:0]   iMemRespData;
  logic                oFillEn;
  logic [INDEX_W-1:0]  oFillIndex;
  logic [TAG_W-1:0]    oFillTag;
  logic [DATA_W-1:0]   oFillData;
  logic                oFwdValid;
  logic [DATA_W-1:0]   oFwdData;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0]         oMissCount;
  logic [31:0]         oDropCount;
`endif

  modport slave (
    input  iAccessValid, iHit, iAddress, iFlush,
    input  iMemReqReady, iMemRespValid, iMemRespData,
    output oStall, oMemReqValid, oMemReqAddr,
    output oFillEn, oFillIndex, oFillTag, oFillData,
    output oFwdValid, oFwdData
`ifdef CACHE_REFILL_STATS_EN
    , output oMissCount, oDropCount
`endif
  );

  modport master (
    output iAccessValid, iHit, iAddress, iFlush,
    output iMemReqReady, iMemRespValid, iMemRespData,
    input  oStall, oMemReqValid, oMemReqAddr,
    input  oFillEn, oFillIndex, oFillTag, oFillData,
    input  oFwdValid, oFwdData
`ifdef CACHE_REFILL_STATS_EN
    , input oMissCount, oDropCount
`endif
  );

endinterface

// File: rtl/cache_refill_stats.sv
// Saturating miss and dropped-fill counters for the refill controller.
// Instantiated only when CACHE_REFILL_STATS_EN is defined.
module cache_refill_stats (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        miss_inc,
  input  logic        drop_inc,
  output logic [31:0] oMissCount,
  output logic [31:0] oDropCount
);

  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign oMissCount = miss_cnt_q;
  assign oDropCount = drop_cnt_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped cache miss handler: request word, fill the array, forward to core.
// Define CACHE_REFILL_STATS_EN to add the miss/drop counters.
//
// state | meaning
// IDLE  | no miss outstanding; stall follows the current access
// REQ   | memory read request presented, waiting for ready
// WAIT  | request accepted, waiting for the response word
// FILL  | one cycle: write array (unless dropped) and forward word
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = cache_pkg::ADDR_W,
  parameter int DATA_W   = cache_pkg::DATA_W,
  parameter int INDEX_W  = cache_pkg::INDEX_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
  input  logic          iClk,
  input  logic          iRst,
  cache_refill_ctrl_if.slave bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

  refill_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                drop_q, drop_d;
  logic                miss;
  logic                fill_cyc;

  // Gated by reset so the combinational stall is also 0 while held in reset.
  assign miss     = iRst && (state_q == IDLE) && bus.iAccessValid && !bus.iHit;
  assign fill_cyc = (state_q == FILL);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          addr_d  = bus.iAddress & ALIGN_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.iFlush)       drop_d  = 1'b1;
        if (bus.iMemReqReady) state_d = WAIT;
      end
      WAIT: begin
        if (bus.iFlush) drop_d = 1'b1;
        if (bus.iMemRespValid) begin
          data_d  = bus.iMemRespData;
          state_d = FILL;
        end
      end
      FILL: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.oStall       = miss || (state_q == REQ) || (state_q == WAIT);
  assign bus.oMemReqValid = (state_q == REQ);
  assign bus.oMemReqAddr  = (state_q == REQ) ? addr_q : '0;

  // A flush landing in the fill cycle itself must also keep the stale line out.
  assign bus.oFillEn    = fill_cyc && !drop_q && !bus.iFlush;
  assign bus.oFillIndex = fill_cyc ? get_index(addr_q) : '0;
  assign bus.oFillTag   = fill_cyc ? get_tag(addr_q)   : '0;
  assign bus.oFillData  = fill_cyc ? data_q : '0;
  assign bus.oFwdValid  = fill_cyc;
  assign bus.oFwdData   = fill_cyc ? data_q : '0;

`ifdef CACHE_REFILL_STATS_EN
  cache_refill_stats u_stats (
    .iClk       (iClk),
    .iRst       (iRst),
    .miss_inc   (miss),
    .drop_inc   (fill_cyc && drop_q),
    .oMissCount (bus.oMissCount),
    .oDropCount (bus.oDropCount)
  );
`endif

endmodule
